rr_arbiter_8: RTL and testbench

Eight-requester round-robin arbiter that produces a registered 3-bit grant index plus a valid flag. Its `gnt_idx` output drives the 3-to-8 one-hot decoder directly downstream, which turns the index into per-channel enables. The arbiter adds hold tracking, an explicit release handshake, and a hold-time watchdog, so that no single channel can monopolise the decoded enable lines.

---
 rtl/rr_arbiter_8.sv | 112 +++++++++++
 tb/tb_rr_arbiter_8.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with a registered grant index,
// an explicit release handshake, withdrawal detection and a hold-time
// watchdog. Every grant is followed by at least one idle cycle, so the
// decoded enables downstream never switch channel back-to-back.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [2:0]      idx_d;
    logic            valid_d;
    logic            timeout_d;

    logic [2:0]      winner;
    logic            found;
    logic [2:0]      cand;

    logic            exit_rel;
    logic            exit_wd;
    logic            exit_lim;

    // Search req starting at ptr and wrapping, first set bit wins.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        cand   = ptr_q;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + i[2:0];
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; the registers below hold the result.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        idx_d     = gnt_idx;
        valid_d   = gnt_valid;
        timeout_d = 1'b0;
        exit_rel  = rel;
        exit_wd   = !req[gnt_idx];
        exit_lim  = (hold_q == HOLD_LAST);

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (found) begin
                    state_d = GRANT;
                    idx_d   = winner;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    ptr_d   = winner + 3'd1;
                end
            end
            GRANT: begin
                if (exit_rel || exit_wd || exit_lim) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    timeout_d = exit_lim && !exit_rel && !exit_wd;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            hold_q    <= '0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_idx   <= idx_d;
            gnt_valid <= valid_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed table-driven checks of rr_arbiter_8 plus
// hand-written multi-cycle sequences for wrap, watchdog, withdrawal and reset.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rel;
        logic [2:0] exp_idx;
        logic       exp_valid;
        logic       exp_timeout;
        string      name;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter_8 #(.MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL time_limit: simulation still running, expected to finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic applyStimulus(input logic r, input logic [7:0] q, input logic l);
        rst = r;
        req = q;
        rel = l;
    endtask

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] e_idx,
                               input logic e_valid, input logic e_to);
        n_checks++;
        if (gnt_idx !== e_idx) begin
            n_fail++;
            $display("[TB] FAIL %s gnt_idx: got %0d expected %0d", name, gnt_idx, e_idx);
        end
        n_checks++;
        if (gnt_valid !== e_valid) begin
            n_fail++;
            $display("[TB] FAIL %s gnt_valid: got %b expected %b", name, gnt_valid, e_valid);
        end
        n_checks++;
        if (timeout !== e_to) begin
            n_fail++;
            $display("[TB] FAIL %s timeout: got %b expected %b", name, timeout, e_to);
        end
    endtask

    function automatic void add(input string n, input logic r, input logic [7:0] q,
                                input logic l, input logic [2:0] ei,
                                input logic ev, input logic et);
        vec_t v;
        v.name = n; v.rst = r; v.req = q; v.rel = l;
        v.exp_idx = ei; v.exp_valid = ev; v.exp_timeout = et;
        vecs.push_back(v);
    endfunction

    initial begin
        applyStimulus(1'b1, 8'hFF, 1'b0);

        // Reset held with all requests pending, then first grant.
        add("rst0",     1, 8'hFF, 0, 3'd0, 0, 0);
        add("rst1",     1, 8'hFF, 0, 3'd0, 0, 0);
        add("rst_rel",  0, 8'hFF, 0, 3'd0, 1, 0);
        add("rel0",     0, 8'hFF, 1, 3'd0, 0, 0);
        // Single requester 3, released on its third grant cycle.
        add("single_g1", 0, 8'h08, 0, 3'd3, 1, 0);
        add("single_g2", 0, 8'h08, 0, 3'd3, 1, 0);
        add("single_g3", 0, 8'h08, 0, 3'd3, 1, 0);
        add("single_rel", 0, 8'h08, 1, 3'd3, 0, 0);
        add("single_re", 0, 8'h08, 0, 3'd3, 1, 0);
        add("single_end", 0, 8'h08, 1, 3'd3, 0, 0);
        // Rotation from ptr=0 with rel held high: 0,1,...,7,0.
        add("rot_rst",  1, 8'h00, 0, 3'd0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            add($sformatf("rot_g%0d", k), 0, 8'hFF, 1, 3'(k % 8), 1, 0);
            add($sformatf("rot_i%0d", k), 0, 8'hFF, 1, 3'(k % 8), 0, 0);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].rel);
            tick();
            checkOutput(vecs[i].name, vecs[i].exp_idx, vecs[i].exp_valid,
                        vecs[i].exp_timeout);
        end

        // Wrap and skip: grant 6 leaves ptr at 7; req 0,1 then wins 0 then 1.
        applyStimulus(1, 8'h00, 0); tick(); checkOutput("wrap_rst", 3'd0, 0, 0);
        applyStimulus(0, 8'h40, 0); tick(); checkOutput("wrap_g6", 3'd6, 1, 0);
        applyStimulus(0, 8'h40, 1); tick(); checkOutput("wrap_r6", 3'd6, 0, 0);
        applyStimulus(0, 8'h03, 0); tick(); checkOutput("wrap_g0", 3'd0, 1, 0);
        applyStimulus(0, 8'h03, 1); tick(); checkOutput("wrap_r0", 3'd0, 0, 0);
        applyStimulus(0, 8'h03, 0); tick(); checkOutput("wrap_g1", 3'd1, 1, 0);
        applyStimulus(0, 8'h03, 1); tick(); checkOutput("wrap_r1", 3'd1, 0, 0);

        // Watchdog: requester 5 held with no release for 16 cycles.
        applyStimulus(1, 8'h00, 0); tick(); checkOutput("wd_rst", 3'd0, 0, 0);
        applyStimulus(0, 8'h20, 0); tick(); checkOutput("wd_c1", 3'd5, 1, 0);
        for (int c = 2; c <= 16; c++) begin
            tick();
            checkOutput($sformatf("wd_c%0d", c), 3'd5, 1, 0);
        end
        tick(); checkOutput("wd_pulse", 3'd5, 0, 1);
        tick(); checkOutput("wd_regrant", 3'd5, 1, 0);
        for (int c = 2; c <= 16; c++) begin
            tick();
            checkOutput($sformatf("wd2_c%0d", c), 3'd5, 1, 0);
        end
        applyStimulus(0, 8'h20, 1); tick(); checkOutput("wd2_tie_rel", 3'd5, 0, 0);
        applyStimulus(0, 8'h00, 0); tick(); checkOutput("wd2_idle", 3'd5, 0, 0);

        // Withdrawal mid-grant ends the grant without a pulse.
        applyStimulus(0, 8'h04, 0); tick(); checkOutput("wdr_g", 3'd2, 1, 0);
        tick(); checkOutput("wdr_g2", 3'd2, 1, 0);
        applyStimulus(0, 8'h00, 0); tick(); checkOutput("wdr_drop", 3'd2, 0, 0);
        tick(); checkOutput("wdr_idle", 3'd2, 0, 0);

        // Reset mid-grant returns every output to its reset value.
        applyStimulus(0, 8'h80, 0); tick(); checkOutput("mrst_g", 3'd7, 1, 0);
        tick(); checkOutput("mrst_g2", 3'd7, 1, 0);
        applyStimulus(1, 8'h80, 0); tick(); checkOutput("mrst_rst", 3'd0, 0, 0);
        applyStimulus(0, 8'h80, 0); tick(); checkOutput("mrst_regrant", 3'd7, 1, 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
